// File: rtl/reorder_buffer.sv
// Eight-entry circular reorder buffer: allocates tags at dispatch, captures
// CDB results, serves operands with same-cycle bypass and retires in order.
module reorder_buffer (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         append,
    input  logic [3:0]   WA,
    input  logic         NoWrite,
    input  logic [143:0] CDB,
    input  logic [5:0]   query,
    output logic [2:0]   ROBTail,
    output logic         full,
    output logic         empty,
    output logic [1:0]   q_ready,
    output logic [63:0]  q_value,
    output logic         RF_WE,
    output logic [3:0]   RF_WA,
    output logic [31:0]  RF_WD,
    output logic         commit
);

    logic [7:0]  busy_q, busy_d;
    logic [7:0]  ready_q, ready_d;
    logic [7:0]  nowrite_q, nowrite_d;
    logic [3:0]  dest_q [8];
    logic [31:0] value_q [8];
    logic [2:0]  head_q, head_d;
    logic [2:0]  tail_q, tail_d;
    logic [3:0]  count_q, count_d;

    logic        cdb_v;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_wr;
    logic        acc;
    logic        unused_cdb;

    assign cdb_v      = CDB[3];
    assign cdb_tag    = CDB[2:0];
    assign cdb_data   = CDB[35:4];
    assign unused_cdb = ^CDB[143:36];
    assign cdb_wr     = cdb_v & busy_q[cdb_tag];

    assign full    = (count_q == 4'd8);
    assign empty   = (count_q == 4'd0);
    assign ROBTail = tail_q;
    assign acc     = append & ~full;

    assign commit = busy_q[head_q] & ready_q[head_q];
    assign RF_WE  = commit & ~nowrite_q[head_q];
    assign RF_WA  = dest_q[head_q];
    assign RF_WD  = value_q[head_q];

    always_comb begin
        busy_d    = busy_q;
        ready_d   = ready_q;
        nowrite_d = nowrite_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q + {3'd0, acc} - {3'd0, commit};
        if (commit) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + 3'd1;
        end
        if (cdb_wr) begin
            ready_d[cdb_tag] = 1'b1;
        end
        // tail entry is never busy when accepted, so no clash with CDB
        if (acc) begin
            busy_d[tail_q]    = 1'b1;
            ready_d[tail_q]   = 1'b0;
            nowrite_d[tail_q] = NoWrite;
            tail_d            = tail_q + 3'd1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            busy_q    <= '0;
            ready_q   <= '0;
            nowrite_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
        end else begin
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            nowrite_q <= nowrite_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (acc) begin
            dest_q[tail_q] <= WA;
        end
        if (cdb_wr) begin
            value_q[cdb_tag] <= cdb_data;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_query
        logic [2:0]  tag;
        logic        rdy;
        logic [31:0] val;

        assign tag = query[3*g +: 3];

        always_comb begin
            rdy = 1'b0;
            val = '0;
            if (busy_q[tag]) begin
                if (cdb_v && (cdb_tag == tag)) begin
                    rdy = 1'b1;
                    val = cdb_data;
                end else begin
                    rdy = ready_q[tag];
                    val = value_q[tag];
                end
            end
        end

        assign q_ready[g]         = rdy;
        assign q_value[32*g +: 32] = val;
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic
// checked against a program-order queue model.
module tb_reorder_buffer;

    logic         CLK = 1'b0;
    logic         Reset;
    logic         append;
    logic [3:0]   WA;
    logic         NoWrite;
    logic [143:0] CDB;
    logic [5:0]   query;
    logic [2:0]   ROBTail;
    logic         full;
    logic         empty;
    logic [1:0]   q_ready;
    logic [63:0]  q_value;
    logic         RF_WE;
    logic [3:0]   RF_WA;
    logic [31:0]  RF_WD;
    logic         commit;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  tag;
        logic [3:0]  dest;
        bit          nw;
        bit          rdy;
        logic [31:0] val;
    } ent_t;

    reorder_buffer dut (
        .CLK(CLK), .Reset(Reset), .append(append), .WA(WA),
        .NoWrite(NoWrite), .CDB(CDB), .query(query),
        .ROBTail(ROBTail), .full(full), .empty(empty),
        .q_ready(q_ready), .q_value(q_value), .RF_WE(RF_WE),
        .RF_WA(RF_WA), .RF_WD(RF_WD), .commit(commit)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    task automatic drv(input bit a, input logic [3:0] wa, input bit nw,
                       input bit cv, input logic [2:0] ct,
                       input logic [31:0] cd, input logic [5:0] qq);
        append  = a;
        WA      = wa;
        NoWrite = nw;
        CDB[127:0]   = {$urandom, $urandom, $urandom, $urandom};
        CDB[143:128] = 16'($urandom);
        CDB[3]    = cv;
        CDB[2:0]  = ct;
        CDB[35:4] = cd;
        query = qq;
    endtask

    task automatic idle(input logic [5:0] qq);
        drv(0, 4'd0, 0, 0, 3'd0, 32'd0, qq);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        idle(6'd0);
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            drv(1, 4'(k + 1), 0, 0, 3'd0, 32'd0, 6'd0);
        end
        @(negedge CLK);
        idle(6'b001_000);
        #1;
        checks++; if (ROBTail !== 3'd3) begin errors++; $display("FAIL pre_rst_tail got %0d exp 3", ROBTail); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL pre_rst_empty got %0b exp 0", empty); end
        #2 Reset = 1'b1;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %0b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %0b exp 0", full); end
        checks++; if (ROBTail !== 3'd0) begin errors++; $display("FAIL rst_tail got %0d exp 0", ROBTail); end
        checks++; if (RF_WE !== 1'b0) begin errors++; $display("FAIL rst_we got %0b exp 0", RF_WE); end
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL rst_commit got %0b exp 0", commit); end
        checks++; if (q_ready !== 2'b00) begin errors++; $display("FAIL rst_qready got %0b exp 00", q_ready); end
        @(negedge CLK);
        Reset = 1'b0;
        drv(1, 4'd9, 0, 0, 3'd0, 32'd0, 6'd0);
        #1;
        checks++; if (ROBTail !== 3'd0) begin errors++; $display("FAIL post_rst_tag got %0d exp 0", ROBTail); end
        @(negedge CLK);
        idle(6'd0);
        #1;
        checks++; if (ROBTail !== 3'd1) begin errors++; $display("FAIL post_rst_adv got %0d exp 1", ROBTail); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL post_rst_empty got %0b exp 0", empty); end
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            drv(1, 4'(i + 1), 0, 0, 3'd0, 32'd0, 6'd0);
            #1;
            checks++; if (ROBTail !== 3'(i)) begin errors++; $display("FAIL fill_tag got %0d exp %0d", ROBTail, i); end
            checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_notfull got %0b exp 0", full); end
        end
        @(negedge CLK);
        drv(1, 4'd9, 0, 0, 3'd0, 32'd0, 6'd0);
        #1;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %0b exp 1", full); end
        checks++; if (ROBTail !== 3'd0) begin errors++; $display("FAIL fill_tail got %0d exp 0", ROBTail); end
        @(negedge CLK);
        drv(0, 4'd0, 0, 1, 3'd0, 32'hAAAA0000, 6'd0);
        #1;
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL cdb_same_cycle got %0b exp 0", commit); end
        checks++; if (ROBTail !== 3'd0) begin errors++; $display("FAIL ninth_ignored got %0d exp 0", ROBTail); end
        @(negedge CLK);
        idle(6'd0);
        #1;
        checks++; if (RF_WE !== 1'b1) begin errors++; $display("FAIL wrap_we got %0b exp 1", RF_WE); end
        checks++; if (RF_WA !== 4'd1) begin errors++; $display("FAIL wrap_wa got %0d exp 1", RF_WA); end
        checks++; if (RF_WD !== 32'hAAAA0000) begin errors++; $display("FAIL wrap_wd got %h exp aaaa0000", RF_WD); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL wrap_stillfull got %0b exp 1", full); end
        @(negedge CLK);
        drv(1, 4'd5, 0, 0, 3'd0, 32'd0, 6'd0);
        #1;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL wrap_notfull got %0b exp 0", full); end
        checks++; if (ROBTail !== 3'd0) begin errors++; $display("FAIL wrap_tag got %0d exp 0", ROBTail); end
        @(negedge CLK);
        idle(6'd0);
        #1;
        checks++; if (ROBTail !== 3'd1) begin errors++; $display("FAIL wrap_adv got %0d exp 1", ROBTail); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL wrap_refull got %0b exp 1", full); end
    endtask

    task automatic test_in_order();
        logic [31:0] vals [3];
        vals[0] = 32'h00001000;
        vals[1] = 32'h00001111;
        vals[2] = 32'h00002222;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            drv(1, 4'(10 + i), 0, 0, 3'd0, 32'd0, 6'd0);
        end
        for (int k = 2; k >= 0; k--) begin
            @(negedge CLK);
            drv(0, 4'd0, 0, 1, 3'(k), vals[k], 6'd0);
            #1;
            checks++; if (commit !== 1'b0) begin errors++; $display("FAIL order_early tag %0d got %0b exp 0", k, commit); end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            idle(6'd0);
            #1;
            checks++; if (commit !== 1'b1) begin errors++; $display("FAIL order_commit %0d got %0b exp 1", k, commit); end
            checks++; if (RF_WE !== 1'b1) begin errors++; $display("FAIL order_we %0d got %0b exp 1", k, RF_WE); end
            checks++; if (RF_WA !== 4'(10 + k)) begin errors++; $display("FAIL order_wa %0d got %0d exp %0d", k, RF_WA, 10 + k); end
            checks++; if (RF_WD !== vals[k]) begin errors++; $display("FAIL order_wd %0d got %h exp %h", k, RF_WD, vals[k]); end
        end
        @(negedge CLK);
        idle(6'd0);
        #1;
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL order_done got %0b exp 0", commit); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL order_empty got %0b exp 1", empty); end
    endtask

    task automatic test_nowrite();
        do_reset();
        @(negedge CLK);
        drv(1, 4'd7, 1, 0, 3'd0, 32'd0, 6'd0);
        @(negedge CLK);
        drv(0, 4'd0, 0, 1, 3'd0, 32'h55, 6'd0);
        #1;
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL nw_early got %0b exp 0", commit); end
        @(negedge CLK);
        idle(6'd0);
        #1;
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL nw_commit got %0b exp 1", commit); end
        checks++; if (RF_WE !== 1'b0) begin errors++; $display("FAIL nw_we got %0b exp 0", RF_WE); end
        @(negedge CLK);
        idle(6'd0);
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL nw_empty got %0b exp 1", empty); end
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL nw_after got %0b exp 0", commit); end
        checks++; if (ROBTail !== 3'd1) begin errors++; $display("FAIL nw_tail got %0d exp 1", ROBTail); end
    endtask

    task automatic test_query_bypass();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            drv(1, 4'(i), 0, 0, 3'd0, 32'd0, 6'd0);
        end
        @(negedge CLK);
        idle({3'd3, 3'd3});
        #1;
        checks++; if (q_ready !== 2'b00) begin errors++; $display("FAIL q_notready got %b exp 00", q_ready); end
        @(negedge CLK);
        drv(0, 4'd0, 0, 1, 3'd3, 32'h12345678, {3'd3, 3'd3});
        #1;
        checks++; if (q_ready !== 2'b11) begin errors++; $display("FAIL q_bypass_rdy got %b exp 11", q_ready); end
        checks++; if (q_value !== {2{32'h12345678}}) begin errors++; $display("FAIL q_bypass_val got %h exp 1234567812345678", q_value); end
        @(negedge CLK);
        idle({3'd3, 3'd3});
        #1;
        checks++; if (q_ready !== 2'b11) begin errors++; $display("FAIL q_stored_rdy got %b exp 11", q_ready); end
        checks++; if (q_value !== {2{32'h12345678}}) begin errors++; $display("FAIL q_stored_val got %h exp 1234567812345678", q_value); end
        @(negedge CLK);
        drv(0, 4'd0, 0, 1, 3'd5, 32'hDEAD, {3'd5, 3'd3});
        #1;
        checks++; if (q_ready !== 2'b01) begin errors++; $display("FAIL q_nonbusy_rdy got %b exp 01", q_ready); end
        checks++; if (q_value[63:32] !== 32'd0) begin errors++; $display("FAIL q_nonbusy_val got %h exp 0", q_value[63:32]); end
    endtask

    task automatic test_full_commit();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            drv(1, 4'(i + 1), 0, 0, 3'd0, 32'd0, 6'd0);
        end
        @(negedge CLK);
        drv(0, 4'd0, 0, 1, 3'd0, 32'hA0, 6'd0);
        @(negedge CLK);
        drv(1, 4'd15, 0, 1, 3'd1, 32'hB1, 6'd0);
        #1;
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL fc_commit got %0b exp 1", commit); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fc_full got %0b exp 1", full); end
        checks++; if (RF_WA !== 4'd1) begin errors++; $display("FAIL fc_wa got %0d exp 1", RF_WA); end
        @(negedge CLK);
        drv(1, 4'd3, 0, 0, 3'd0, 32'd0, 6'd0);
        #1;
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fc_seven got %0b exp 0", full); end
        checks++; if (ROBTail !== 3'd0) begin errors++; $display("FAIL fc_rejected got %0d exp 0", ROBTail); end
        checks++; if (commit !== 1'b1) begin errors++; $display("FAIL fc_commit2 got %0b exp 1", commit); end
        checks++; if (RF_WD !== 32'hB1) begin errors++; $display("FAIL fc_wd2 got %h exp b1", RF_WD); end
        @(negedge CLK);
        idle(6'd0);
        #1;
        checks++; if (ROBTail !== 3'd1) begin errors++; $display("FAIL fc_tail_adv got %0d exp 1", ROBTail); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL fc_count7 got %0b exp 0", full); end
        checks++; if (commit !== 1'b0) begin errors++; $display("FAIL fc_head_adv got %0b exp 0", commit); end
        @(negedge CLK);
        drv(1, 4'd4, 0, 0, 3'd0, 32'd0, 6'd0);
        @(negedge CLK);
        idle(6'd0);
        #1;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fc_refill got %0b exp 1", full); end
        checks++; if (ROBTail !== 3'd2) begin errors++; $display("FAIL fc_refill_tail got %0d exp 2", ROBTail); end
    endtask

    task automatic test_random();
        ent_t        q[$];
        ent_t        e;
        logic [2:0]  nt;
        nt = 3'd0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            bit          a, nw, cv, busy_ph, ec, er, acc;
            logic [3:0]  wa;
            logic [2:0]  ct, t;
            logic [31:0] cd, ev;
            logic [5:0]  qq;
            busy_ph = ((c / 60) % 2) == 1;
            @(negedge CLK);
            a  = $urandom_range(99) < (busy_ph ? 80 : 35);
            wa = 4'($urandom);
            nw = $urandom_range(4) == 0;
            cv = $urandom_range(99) < (busy_ph ? 35 : 75);
            if (q.size() > 0 && $urandom_range(4) != 0)
                ct = q[$urandom_range(q.size() - 1)].tag;
            else
                ct = 3'($urandom);
            cd = $urandom;
            qq = 6'($urandom);
            drv(a, wa, nw, cv, ct, cd, qq);
            #1;
            ec = (q.size() > 0) && q[0].rdy;
            checks++; if (commit !== ec) begin errors++; $display("FAIL rnd_commit cyc %0d got %0b exp %0b", c, commit, ec); end
            checks++; if (RF_WE !== (ec && !q[0].nw)) begin errors++; $display("FAIL rnd_we cyc %0d got %0b exp %0b", c, RF_WE, ec && !q[0].nw); end
            if (ec) begin
                checks++; if (RF_WA !== q[0].dest) begin errors++; $display("FAIL rnd_wa cyc %0d got %0d exp %0d", c, RF_WA, q[0].dest); end
                checks++; if (RF_WD !== q[0].val) begin errors++; $display("FAIL rnd_wd cyc %0d got %h exp %h", c, RF_WD, q[0].val); end
            end
            checks++; if (full !== (q.size() == 8)) begin errors++; $display("FAIL rnd_full cyc %0d got %0b exp %0b", c, full, q.size() == 8); end
            checks++; if (empty !== (q.size() == 0)) begin errors++; $display("FAIL rnd_empty cyc %0d got %0b exp %0b", c, empty, q.size() == 0); end
            checks++; if (ROBTail !== nt) begin errors++; $display("FAIL rnd_tail cyc %0d got %0d exp %0d", c, ROBTail, nt); end
            for (int i = 0; i < 2; i++) begin
                t  = qq[3*i +: 3];
                er = 1'b0;
                ev = 32'd0;
                foreach (q[j]) begin
                    if (q[j].tag == t) begin
                        er = (cv && ct == t) ? 1'b1 : q[j].rdy;
                        ev = (cv && ct == t) ? cd : q[j].val;
                    end
                end
                checks++; if (q_ready[i] !== er) begin errors++; $display("FAIL rnd_qrdy%0d cyc %0d got %0b exp %0b", i, c, q_ready[i], er); end
                if (er || ev == 32'd0 && !er && !(q.size() > 0)) begin
                    checks++; if (q_value[32*i +: 32] !== ev) begin errors++; $display("FAIL rnd_qval%0d cyc %0d got %h exp %h", i, c, q_value[32*i +: 32], ev); end
                end
            end
            acc = a && (q.size() < 8);
            if (cv) begin
                foreach (q[j]) begin
                    if (q[j].tag == ct) begin
                        q[j].rdy = 1'b1;
                        q[j].val = cd;
                    end
                end
            end
            if (ec) void'(q.pop_front());
            if (acc) begin
                e.tag  = nt;
                e.dest = wa;
                e.nw   = nw;
                e.rdy  = 1'b0;
                e.val  = 32'd0;
                q.push_back(e);
                nt = nt + 3'd1;
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        idle(6'd0);
        test_reset();
        test_fill_wrap();
        test_in_order();
        test_nowrite();
        test_query_bypass();
        test_full_commit();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Eight-entry circular reorder buffer for the Tomasulo core. It allocates a ROB tag at dispatch and feeds that tag (`ROBTail`) and the `append`/`NoWrite`/`WA` handshake to the register result status table. It captures results from the common data bus, serves operand values to dispatch, and retires instructions in program order into the architectural register file, one per cycle.

## Interface
Parameters: none. Depth 8, tag 3 bits, data 32 bits, 16 architectural registers are fixed.
- `CLK` in 1: clock, rising edge.
- `Reset` in 1: asynchronous, active-high.
- `append` in 1: dispatch request for one instruction this cycle.
- `WA` in 4: destination architectural register of the dispatching instruction.
- `NoWrite` in 1: dispatching instruction has no register destination.
- `CDB` in 144: common data bus. This block uses only slot 0:
  - `CDB[3]`: valid.
  - `CDB[2:0]`: ROB tag.
  - `CDB[35:4]`: 32-bit result.
  - All other bits are ignored.
- `query` in 6: two operand tags, `[2:0]` for operand 0 and `[5:3]` for operand 1.
- `ROBTail` out 3: tag that the next accepted `append` receives.
- `full` out 1: 8 entries allocated.
- `empty` out 1: 0 entries allocated.
- `q_ready` out 2: bit i means the entry named by query tag i holds its result.
- `q_value` out 64: `[31:0]` is the operand 0 value, `[63:32]` is the operand 1 value.
- `RF_WE` out 1: register file write enable (commit).
- `RF_WA` out 4: register file write address.
- `RF_WD` out 32: register file write data.
- `commit` out 1: head entry retires at this clock edge.

## Operation
- Per-entry state: `busy`, `ready`, `nowrite`, `dest[3:0]`, `value[31:0]`. Pointers: `head[2:0]`, `tail[2:0]`, `count[3:0]` (range 0..8).
- Accept:
  - `acc = append & ~full`.
  - On `acc`: entry[tail] gets busy=1, ready=0, dest=`WA`, nowrite=`NoWrite`; `tail` increments mod 8.
  - `append` while `full` is dropped with no state change. Upstream must hold `append` low while `full`.
- Writeback:
  - When `CDB[3]` is high and entry[`CDB[2:0]`].busy is 1: set ready=1 and value=`CDB[35:4]`.
  - A CDB write to a non-busy entry is ignored.
  - A CDB write to an already-ready entry overwrites its value.
- Commit:
  - `commit = busy[head] & ready[head]`, combinational.
  - `RF_WE = commit & ~nowrite[head]`; `RF_WA = dest[head]`; `RF_WD = value[head]`.
  - On the edge: busy[head] clears and `head` increments mod 8.
  - `nowrite` entries retire without a register file write.
- Count: `count_next = count + acc - commit`. `full = (count == 8)`, `empty = (count == 0)`, `ROBTail = tail`.
- Operand query, per port i, combinational:
  - If `CDB[3]` is high, `CDB[2:0]` equals the query tag, and that entry is busy: `q_ready[i]=1`, value is `CDB[35:4]` (bypass).
  - Otherwise `q_ready[i]` is `busy & ready` of the queried entry, and the value is the stored value.
  - A non-busy queried entry returns `q_ready=0` and value 0.
- Simultaneous events:
  - **Accept and commit in the same cycle:** both take effect; count is unchanged.
  - **`full` and commit in the same cycle:** `append` is still rejected, because `full` is evaluated on the current count.
  - **Accept when `head == tail`** (empty): legal. The new entry cannot commit in that cycle because busy was 0.
  - **CDB to the head entry:** commit happens in the following cycle, never the same cycle.
- Reset (asynchronous, including mid-operation): clears all busy/ready bits, `head=tail=0`, `count=0`. Entry `value`/`dest` need not be reset.
  - Outputs during reset: `full=0`, `empty=1`, `ROBTail=0`, `commit=0`, `RF_WE=0`, `q_ready=0`.
  - In-flight instructions are discarded.

## Timing
- Dispatch at edge E: `ROBTail` before E is the assigned tag. The entry is busy, and `ROBTail` is advanced, after E.
- CDB writeback to head in cycle C: `commit`/`RF_WE` go high in cycle C+1, and the register file is written at the end of C+1.
- Minimum dispatch-to-retire time: CDB in the cycle after dispatch, commit in the cycle after that.
- Commit throughput: 1 per cycle. Dispatch throughput: 1 per cycle.
- `q_ready`/`q_value` are valid in the same cycle as `query`, including the same-cycle CDB bypass.

## Test plan
- **Reset state:** assert `Reset` mid-cycle with 3 entries allocated → immediately `empty=1`, `full=0`, `ROBTail=0`, `RF_WE=0`. After release, the first append receives tag 0.
- **Fill, block, wrap:**
  - 8 appends (WA=1..8) with no CDB → tags 0..7, `full=1` after the 8th.
  - A 9th append is ignored, and `ROBTail` stays 0.
  - CDB tag 0 value 0xAAAA0000 → next cycle `RF_WE=1`, `RF_WA=1`, `RF_WD=0xAAAA0000`, then `full=0`.
  - The following append receives tag 0 (wrap-around).
- **In-order retire:**
  - Tags 0,1,2 allocated. CDB completes tag 2, then tag 1 → no commit occurs.
  - CDB completes tag 0 → commits of tags 0,1,2 in 3 consecutive cycles, in that order, each with the correct WA/WD.
- **NoWrite retire:** dispatch with `NoWrite=1` and complete it via CDB → `commit=1`, `RF_WE=0`, head advances, `empty=1`.
- **Query and bypass:**
  - Tag 3 busy but not ready; `query={tag3,tag3}` → `q_ready=00`.
  - Same cycle CDB tag 3 value 0x12345678 → `q_ready=11`, both values 0x12345678.
  - Next cycle, without CDB → still 11 with value 0x12345678.
- **Simultaneous accept and commit at full:**
  - 8 entries, head ready, `append` high → commit occurs, the append is rejected, and count becomes 7.
  - With 7 entries, accept and commit in the same cycle → count stays 7, `tail` and `head` both advance.
